keccak_pad: RTL and testbench
=============================

Name: keccak_pad

Overview:
- Upstream stage of the Keccak permutation core. Accepts a message as a stream of 64-bit little-endian words.
- Packs the words into rate lanes and applies SHA-3 multi-rate padding (domain byte, then final 0x80).
- Presents complete 25-lane blocks with a last-block flag through a valid/ready handshake. Capacity lanes are always zero.

Parameters:
- WIDTH, 64, lane width in bits. Only 64 is supported.
- RATE_LANES, 17, lanes per block carrying message data (17 = SHA3-256). Legal range is 1..24.
- DOMAIN, 8'h06, domain-separation pad byte (8'h1F for SHAKE).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- nrst  in  1  reset, synchronous, active-low.
- in_data  in  WIDTH  message word; byte b is in_data[8b+7:8b].
- in_valid  in  1  in_data is valid.
- in_last  in  1  this word is the final word of the message.
- in_bytes  in  4  valid bytes in the final word, 0..8. Sampled only with in_last. Values 9..15 are treated as 8.
- in_ready  out  1  block accepts a word this cycle.
- Dout  out  [0:4][0:4][WIDTH-1:0]  block; Dout[x][y] holds lane 5*y+x.
- block_valid  out  1  Dout holds a complete block.
- block_last  out  1  Dout is the final block of the message.
- block_ready  in  1  consumer takes the block this cycle.
- lane_cnt  out  5  next lane index to be filled (debug).

Behaviour:
- Reset: synchronous; applies while nrst=0 on a clock edge.
  - Clears the state to FILL, lane_cnt=0, pad_pending=0.
  - Outputs: Dout=0, block_valid=0, block_last=0, in_ready=0 while nrst=0.
  - Reset mid-block or mid-HOLD discards all buffered data; no partial block is ever emitted.
- A word transfers when in_valid && in_ready. A block transfers when block_valid && block_ready.
- States: FILL, HOLD, PADBLK.
- FILL:
  - in_ready=1 and block_valid=0.
  - A transferred word is written to lane lane_cnt, then lane_cnt increments.
  - Non-last word at lane_cnt=RATE_LANES-1: go to HOLD with block_last=0.
  - Last word with n=in_bytes (0..8):
    - Bytes 0..n-1 are taken from in_data; bytes n..7 are forced to 0, so junk is masked.
    - If n<8: DOMAIN is XORed into byte n of the current lane. The block closes with block_last=1 and goes to HOLD.
    - If n=8 and lane_cnt<RATE_LANES-1: DOMAIN is XORed into byte 0 of lane lane_cnt+1. The block closes with block_last=1 and goes to HOLD.
    - If n=8 and lane_cnt=RATE_LANES-1: the data block closes with block_last=0, pad_pending is set, and the state goes to HOLD.
    - For every block closed with block_last=1, 0x80 is XORed into byte 7 of lane RATE_LANES-1. When it coincides with DOMAIN it combines (0x06^0x80=0x86).
  - All unwritten rate lanes and all capacity lanes (RATE_LANES..24) are 0.
- Latency: block_valid rises the cycle after the closing word is transferred.
- HOLD:
  - in_ready=0. block_valid=1. Dout and block_last are stable until transfer.
  - On transfer:
    - If pad_pending: go to PADBLK.
    - Otherwise: clear the buffer, set lane_cnt=0, and go to FILL (in_ready=1 next cycle).
- PADBLK:
  - Takes one cycle; in_ready=0, block_valid=0.
  - Builds a padding-only block: lane0 byte0=DOMAIN, lane RATE_LANES-1 byte7 ^= 0x80, all else 0.
  - Sets block_last=1, clears pad_pending, and goes to HOLD.
- Multiple messages run back to back. A new message starts in FILL with lane_cnt=0.
- in_valid while in_ready=0 is ignored; the producer must hold the word.
- block_ready while block_valid=0 is ignored.

Test Plan:
- Empty message: one word, in_last=1, in_bytes=0 -> one block, block_last=1, lane0=64'h06, lane16=64'h8000000000000000, all other lanes 0.
- "abc": in_data=64'hDEADBEEF00636261, in_last=1, in_bytes=3 -> lane0=64'h0000000006636261 (junk masked), lane16=64'h8000000000000000, block_last=1.
- 17 full words 1..17, the last with in_bytes=8 -> block A has lanes 0..16 = 1..17 and block_last=0; then block B is pad-only: lane0=64'h06, lane16=64'h8000000000000000, block_last=1.
- 16 full words, then in_last with in_bytes=7 and data 64'h00FFFFFFFFFFFFFF -> lane16=64'h86FFFFFFFFFFFFFF, block_last=1.
- Backpressure: block_ready=0 for 10 cycles after block_valid rises -> Dout and block_last stable, in_ready=0 throughout, in_valid words not consumed; block_ready=1 -> in_ready=1 the next cycle.
- Reset mid-fill: 5 words sent, nrst=0 for 1 cycle, then "abc" -> the block equals the "abc" case exactly, with lane_cnt=0 after reset.

Source files
------------

// File: rtl/keccak_pad.sv
// Keccak input stage: packs 64-bit little-endian message words into rate lanes,
// applies SHA-3 multi-rate padding and hands complete 25-lane blocks downstream.
module keccak_pad #(
  parameter int         WIDTH      = 64,
  parameter int         RATE_LANES = 17,
  parameter logic [7:0] DOMAIN     = 8'h06
) (
  input  logic                         clk,
  input  logic                         nrst,
  input  logic [WIDTH-1:0]             in_data,
  input  logic                         in_valid,
  input  logic                         in_last,
  input  logic [3:0]                   in_bytes,
  output logic                         in_ready,
  output logic [0:4][0:4][WIDTH-1:0]   Dout,
  output logic                         block_valid,
  output logic                         block_last,
  input  logic                         block_ready,
  output logic [4:0]                   lane_cnt
);

  localparam int         NLANES    = 25;
  localparam int         NBYTES    = WIDTH / 8;
  localparam logic [4:0] LAST_LANE = 5'(RATE_LANES - 1);

  typedef enum logic [1:0] {
    S_FILL,
    S_HOLD,
    S_PADBLK
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] lanes_q [NLANES];
  logic [WIDTH-1:0] lanes_d [NLANES];
  logic [4:0]       lane_cnt_q, lane_cnt_d;
  logic             pad_pending_q, pad_pending_d;
  logic             block_last_q, block_last_d;

  logic             word_xfer;
  logic             blk_xfer;
  logic [3:0]       n_bytes;
  logic [WIDTH-1:0] word_fill;
  logic             close_last;

  assign in_ready    = nrst && (state_q == S_FILL);
  assign block_valid = nrst && (state_q == S_HOLD);
  assign block_last  = nrst && block_last_q;
  assign lane_cnt    = lane_cnt_q;

  assign word_xfer = in_valid && in_ready;
  assign blk_xfer  = block_valid && block_ready;

  // Final-word shaping: keep the valid bytes, zero the junk and drop the
  // domain byte right after the data when it still fits in this lane.
  always_comb begin
    n_bytes   = (in_bytes > 4'd8) ? 4'd8 : in_bytes;
    word_fill = in_data;
    if (in_last) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (4'(b) == n_bytes) begin
          word_fill[8*b +: 8] = DOMAIN;
        end else if (4'(b) > n_bytes) begin
          word_fill[8*b +: 8] = '0;
        end
      end
    end
  end

  // NOTE: every signal written here gets its default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    lanes_d       = lanes_q;
    lane_cnt_d    = lane_cnt_q;
    pad_pending_d = pad_pending_q;
    block_last_d  = block_last_q;
    close_last    = 1'b0;

    case (state_q)
      S_FILL: begin
        if (word_xfer) begin
          lanes_d[lane_cnt_q] = word_fill;
          lane_cnt_d          = lane_cnt_q + 5'd1;
          if (in_last) begin
            state_d = S_HOLD;
            if ((n_bytes == 4'd8) && (lane_cnt_q == LAST_LANE)) begin
              // Message fills the rate exactly: padding needs a block of its own.
              block_last_d  = 1'b0;
              pad_pending_d = 1'b1;
            end else begin
              if (n_bytes == 4'd8) begin
                lanes_d[lane_cnt_q + 5'd1][7:0] = lanes_d[lane_cnt_q + 5'd1][7:0] ^ DOMAIN;
              end
              block_last_d = 1'b1;
              close_last   = 1'b1;
            end
          end else if (lane_cnt_q == LAST_LANE) begin
            state_d      = S_HOLD;
            block_last_d = 1'b0;
          end
        end
      end

      S_HOLD: begin
        if (blk_xfer) begin
          if (pad_pending_q) begin
            state_d = S_PADBLK;
          end else begin
            lanes_d      = '{default: '0};
            lane_cnt_d   = '0;
            block_last_d = 1'b0;
            state_d      = S_FILL;
          end
        end
      end

      S_PADBLK: begin
        lanes_d         = '{default: '0};
        lanes_d[0][7:0] = DOMAIN;
        close_last      = 1'b1;
        block_last_d    = 1'b1;
        pad_pending_d   = 1'b0;
        state_d         = S_HOLD;
      end

      default: begin
        state_d = S_FILL;
      end
    endcase

    // Closing 0x80 XORs in so it merges with DOMAIN when both land on one byte.
    if (close_last) begin
      lanes_d[RATE_LANES-1][WIDTH-1 -: 8] = lanes_d[RATE_LANES-1][WIDTH-1 -: 8] ^ 8'h80;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q       <= S_FILL;
      lane_cnt_q    <= '0;
      pad_pending_q <= 1'b0;
      block_last_q  <= 1'b0;
      // NOTE: the lane buffer is reset on purpose; padding XORs into lanes that
      // must already be zero, and a reset must discard any partial block.
      lanes_q       <= '{default: '0};
    end else begin
      state_q       <= state_d;
      lane_cnt_q    <= lane_cnt_d;
      pad_pending_q <= pad_pending_d;
      block_last_q  <= block_last_d;
      lanes_q       <= lanes_d;
    end
  end

  // Dout[x][y] carries lane 5*y+x; forced to zero while reset is held.
  always_comb begin
    Dout = '0;
    if (nrst) begin
      for (int y = 0; y < 5; y++) begin
        for (int x = 0; x < 5; x++) begin
          Dout[x][y] = lanes_q[5*y + x];
        end
      end
    end
  end

endmodule

// File: tb/tb_keccak_pad.sv
// Self-checking bench for keccak_pad: a byte-level SHA-3 padding model fills a
// scoreboard of expected blocks that are compared as the DUT hands them out.
module tb_keccak_pad;

  localparam int         R   = 17;
  localparam logic [7:0] DOM = 8'h06;

  logic                     clk;
  logic                     nrst;
  logic [63:0]              in_data;
  logic                     in_valid;
  logic                     in_last;
  logic [3:0]               in_bytes;
  logic                     in_ready;
  logic [0:4][0:4][63:0]    Dout;
  logic                     block_valid;
  logic                     block_last;
  logic                     block_ready;
  logic [4:0]               lane_cnt;

  typedef struct packed {
    logic [24:0][63:0] lanes;
    logic              last;
  } blk_t;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
    logic [3:0]  nb;
  } word_t;

  blk_t        exp_q[$];
  word_t       stim_q[$];
  logic [63:0] msg_q[$];
  int          total;
  int          bad;

  keccak_pad #(.WIDTH(64), .RATE_LANES(R), .DOMAIN(DOM)) dut (
    .clk         (clk),
    .nrst        (nrst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_last     (in_last),
    .in_bytes    (in_bytes),
    .in_ready    (in_ready),
    .Dout        (Dout),
    .block_valid (block_valid),
    .block_last  (block_last),
    .block_ready (block_ready),
    .lane_cnt    (lane_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Turns msg_q into stimulus words and expected blocks via pad10*1 on bytes.
  task automatic commit_msg(input logic [3:0] nb);
    logic [7:0] b_q[$];
    int         nbc;
    int         nblk;
    int         cnt;
    blk_t       e;
    word_t      w;
    nbc = (nb > 4'd8) ? 8 : int'(nb);
    for (int i = 0; i < msg_q.size(); i++) begin
      cnt = (i == msg_q.size() - 1) ? nbc : 8;
      for (int b = 0; b < cnt; b++) b_q.push_back(msg_q[i][8*b +: 8]);
      w.data = msg_q[i];
      w.last = (i == msg_q.size() - 1);
      w.nb   = nb;
      stim_q.push_back(w);
    end
    b_q.push_back(DOM);
    while (b_q.size() % (R*8) != 0) b_q.push_back(8'h00);
    b_q[b_q.size()-1] = b_q[b_q.size()-1] ^ 8'h80;
    nblk = b_q.size() / (R*8);
    for (int k = 0; k < nblk; k++) begin
      e = '0;
      for (int l = 0; l < R; l++)
        for (int b = 0; b < 8; b++)
          e.lanes[l][8*b +: 8] = b_q[k*R*8 + l*8 + b];
      e.last = (k == nblk - 1);
      exp_q.push_back(e);
    end
    msg_q.delete();
  endtask

  task automatic send_word(input logic [63:0] d, input logic l, input logic [3:0] nb);
    int cnt;
    in_data  = d;
    in_last  = l;
    in_bytes = nb;
    in_valid = 1'b1;
    cnt      = 0;
    while (!in_ready && cnt < 1000) begin
      @(negedge clk);
      cnt++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
    end else begin
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain_stim();
    word_t w;
    while (stim_q.size() > 0) begin
      w = stim_q.pop_front();
      send_word(w.data, w.last, w.nb);
    end
  endtask

  task automatic receive_blocks();
    int   cnt;
    blk_t e;
    while (exp_q.size() > 0) begin
      cnt = 0;
      while (!block_valid && cnt < 2000) begin
        @(negedge clk);
        cnt++;
      end
      total++;
      if (!block_valid) begin
        bad++;
        $display("FAIL block_timeout: block_valid=%b required 1 (%0d blocks pending)",
                 block_valid, exp_q.size());
        exp_q.delete();
      end else begin
        e = exp_q.pop_front();
        for (int i = 0; i < 25; i++) begin
          total++;
          if (Dout[i%5][i/5] !== e.lanes[i]) begin
            bad++;
            $display("FAIL lane%0d: got %h required %h", i, Dout[i%5][i/5], e.lanes[i]);
          end
        end
        if (block_last !== e.last) begin
          bad++;
          $display("FAIL block_last: got %b required %b", block_last, e.last);
        end
        block_ready = 1'b1;
        @(negedge clk);
        block_ready = 1'b0;
      end
    end
  endtask

  task automatic run_msgs();
    fork
      drain_stim();
      receive_blocks();
    join
  endtask

  task automatic wait_block_valid(input string tag);
    int cnt;
    cnt = 0;
    while (!block_valid && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    total++;
    if (!block_valid) begin
      bad++;
      $display("FAIL %s_valid_timeout: block_valid=%b required 1", tag, block_valid);
    end
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (in_ready !== 1'b0 || block_valid !== 1'b0 || block_last !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctrl: in_ready=%b block_valid=%b block_last=%b required 0 0 0",
               in_ready, block_valid, block_last);
    end
    total++;
    if (Dout !== '0) begin
      bad++;
      $display("FAIL reset_dout: got nonzero lane0=%h required 0", Dout[0][0]);
    end
    nrst = 1'b1;
    @(negedge clk);
    total++;
    if (lane_cnt !== 5'd0 || in_ready !== 1'b1 || block_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: lane_cnt=%0d in_ready=%b block_valid=%b required 0 1 0",
               lane_cnt, in_ready, block_valid);
    end
  endtask

  task automatic test_empty();
    msg_q.push_back(64'hFFFF_0000_1234_5678);
    commit_msg(4'd0);
    run_msgs();
  endtask

  task automatic test_abc();
    msg_q.push_back(64'hDEADBEEF00636261);
    commit_msg(4'd3);
    run_msgs();
  endtask

  task automatic test_full_rate();
    for (int i = 1; i <= R; i++) msg_q.push_back(64'(i));
    commit_msg(4'd8);
    run_msgs();
  endtask

  task automatic test_domain_merge();
    for (int i = 0; i < R-1; i++) msg_q.push_back(64'h1111_0000_0000_0000 + 64'(i));
    msg_q.push_back(64'h00FFFFFFFFFFFFFF);
    commit_msg(4'd7);
    run_msgs();
  endtask

  task automatic test_next_lane();
    for (int i = 0; i < 3; i++) msg_q.push_back(64'hA5A5_0000_0000_0000 + 64'(i));
    commit_msg(4'd8);
    msg_q.push_back(64'hCAFE_F00D_0BAD_BEEF);
    commit_msg(4'd12);
    run_msgs();
  endtask

  task automatic test_backpressure();
    word_t w;
    blk_t  e;
    logic  same;
    msg_q.push_back(64'hDEADBEEF00636261);
    commit_msg(4'd3);
    msg_q.push_back(64'h0123_4567_89AB_7777);
    commit_msg(4'd2);
    w = stim_q.pop_front();
    send_word(w.data, w.last, w.nb);
    wait_block_valid("bp");
    e = exp_q[0];
    w = stim_q.pop_front();
    in_data  = w.data;
    in_last  = w.last;
    in_bytes = w.nb;
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      same = 1'b1;
      for (int i = 0; i < 25; i++) if (Dout[i%5][i/5] !== e.lanes[i]) same = 1'b0;
      total++;
      if (!same || block_last !== e.last) begin
        bad++;
        $display("FAIL bp_stable cycle %0d: lane0=%h last=%b required lane0=%h last=%b",
                 c, Dout[0][0], block_last, e.lanes[0], e.last);
      end
      total++;
      if (in_ready !== 1'b0 || block_valid !== 1'b1 || lane_cnt !== 5'd1) begin
        bad++;
        $display("FAIL bp_hold cycle %0d: in_ready=%b block_valid=%b lane_cnt=%0d required 0 1 1",
                 c, in_ready, block_valid, lane_cnt);
      end
      @(negedge clk);
    end
    block_ready = 1'b1;
    @(negedge clk);
    block_ready = 1'b0;
    void'(exp_q.pop_front());
    total++;
    if (in_ready !== 1'b1 || block_valid !== 1'b0 || lane_cnt !== 5'd0) begin
      bad++;
      $display("FAIL bp_release: in_ready=%b block_valid=%b lane_cnt=%0d required 1 0 0",
               in_ready, block_valid, lane_cnt);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    receive_blocks();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) send_word(64'h5555_0000_0000_0000 + 64'(i), 1'b0, 4'd0);
    nrst = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    total++;
    if (lane_cnt !== 5'd0 || block_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_fill: lane_cnt=%0d block_valid=%b required 0 0", lane_cnt, block_valid);
    end
    test_abc();
    // Reset while a finished block waits: the block must vanish.
    send_word(64'h0000_0000_0000_4242, 1'b1, 4'd2);
    wait_block_valid("rst_hold");
    nrst = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    total++;
    if (block_valid !== 1'b0 || in_ready !== 1'b1 || lane_cnt !== 5'd0) begin
      bad++;
      $display("FAIL rst_mid_hold: block_valid=%b in_ready=%b lane_cnt=%0d required 0 1 0",
               block_valid, in_ready, lane_cnt);
    end
    test_abc();
  endtask

  task automatic test_back_to_back();
    int len;
    for (int m = 0; m < 4; m++) begin
      len = $urandom_range(0, 40);
      for (int i = 0; i <= len; i++) msg_q.push_back({$urandom, $urandom});
      commit_msg(4'($urandom_range(0, 15)));
    end
    run_msgs();
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    nrst        = 1'b0;
    in_data     = '0;
    in_valid    = 1'b0;
    in_last     = 1'b0;
    in_bytes    = '0;
    block_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_empty();
    test_abc();
    test_full_rate();
    test_domain_merge();
    test_next_lane();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
